io_port_responder: RTL and testbench
====================================

IO_PORT_RESPONDER -- requirements
Module: io_port_responder

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 36, width of one I/O port word.
REQ-002 SHALL have parameter DEPTH, default 4, entries per FIFO; power of two, at least 2.
REQ-003 SHALL have parameter ADDR_WIDTH, default 2, equal to log2(DEPTH).
REQ-004 SHALL use one clock and an asynchronous active-low reset, with ports named as in the codebase.
REQ-005 clock  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 io_wren  in  1  datapath write strobe for this port.
REQ-008 io_out  in  WORD_WIDTH  word written by datapath.
REQ-009 io_rden  in  1  datapath read strobe for this port.
REQ-010 io_in  out  WORD_WIDTH  word presented to datapath.
REQ-011 io_out_ready  out  1  outbound FIFO not full.
REQ-012 io_in_valid  out  1  inbound FIFO not empty.
REQ-013 ext_out_data  out  WORD_WIDTH  outbound head word.
REQ-014 ext_out_valid  out  1  outbound FIFO not empty.
REQ-015 ext_out_ready  in  1  external sink accepts word.
REQ-016 ext_in_data  in  WORD_WIDTH  external source word.
REQ-017 ext_in_valid  in  1  external source offers word.
REQ-018 ext_in_ready  out  1  inbound FIFO not full.
REQ-019 err_clear  in  1  clears both sticky error flags.
REQ-020 io_write_overflow  out  1  sticky: datapath write was dropped.
REQ-021 io_read_underflow  out  1  sticky: datapath read found the inbound FIFO empty.

Function
REQ-022 The outbound FIFO SHALL push io_out when io_wren=1 and the push is accepted, and SHALL pop when ext_out_valid and ext_out_ready are both 1.
REQ-023 The inbound FIFO SHALL push ext_in_data when ext_in_valid and ext_in_ready are both 1, and SHALL pop when io_rden=1 and io_in_valid=1.
REQ-024 An outbound push while the FIFO is full SHALL be accepted only if a pop occurs in the same cycle (count unchanged); otherwise the word SHALL be dropped and io_write_overflow set.
REQ-025 ext_in_ready SHALL depend only on registered state (count < DEPTH); a same-cycle pop SHALL NOT raise it.
REQ-026 Simultaneous push and pop on a non-empty, non-full FIFO SHALL leave the count unchanged and advance both pointers.
REQ-027 Both FIFOs SHALL be show-ahead: io_in and ext_out_data equal the head entry, driven from registers, with zero combinational path from any input.
REQ-028 io_in SHALL be 0 when the inbound FIFO is empty; ext_out_data is don't-care when ext_out_valid=0.
REQ-029 io_rden=1 while io_in_valid=0 SHALL set io_read_underflow and leave FIFO state unchanged.
REQ-030 A word pushed at edge N SHALL be visible at the FIFO head (valid=1) after edge N, i.e. 1-cycle latency.
REQ-031 Pointers SHALL be ADDR_WIDTH bits wrapping modulo DEPTH; counts SHALL be ADDR_WIDTH+1 bits ranging 0..DEPTH.
REQ-032 When err_clear and an error-set event occur in the same cycle, the set SHALL win.
REQ-033 FIFO order SHALL be strictly first-in first-out; no word SHALL be duplicated or reordered.

Reset
REQ-034 reset_n=0 SHALL immediately empty both FIFOs, force io_out_ready=1, ext_in_ready=1, io_in_valid=0, ext_out_valid=0, io_in=0, and clear both error flags.
REQ-035 Reset asserted mid-transfer SHALL discard all buffered words; storage contents need no reset.
REQ-036 After reset_n rises, the first push SHALL be accepted on the first subsequent clock edge.

Structure
REQ-037 The FIFO SHALL be one sub-module, fifo_sync (storage, pointers, count, full/empty), instantiated twice.
REQ-038 No typedefs are needed; the default port word width constant SHALL live in the shared parameter header used by the datapath.

Verification
REQ-039 DEPTH=4: four io_wren writes 0x1..0x4 with ext_out_ready=0 -> io_out_ready=0; a fifth write 0x5 -> dropped, io_write_overflow=1; then ext_out_ready=1 -> ext_out_data sequence 0x1,0x2,0x3,0x4.
REQ-040 Full outbound FIFO, io_wren with 0xA and an ext pop in the same cycle -> write accepted, overflow stays 0, count stays 4.
REQ-041 io_rden with inbound FIFO empty -> io_in=0, io_read_underflow=1; err_clear pulse -> flag 0; err_clear coinciding with a second underflow -> flag stays 1.
REQ-042 Push 0x123 on ext_in -> next cycle io_in_valid=1, io_in=0x123; io_rden -> next cycle io_in_valid=0, io_in=0.
REQ-043 Ten interleaved push/pop cycles across pointer wrap on both FIFOs -> output order matches input order and no flags are set.
REQ-044 reset_n pulsed low with 3 words buffered in each FIFO -> all valids 0 and readies 1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/io_port_responder_pkg.sv
// rtl/io_port_responder_pkg.sv - shared I/O port parameter header
package io_port_responder_pkg;
  localparam int IO_WORD_WIDTH = 36;
  localparam int IO_FIFO_DEPTH = 4;
endpackage

// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - show-ahead synchronous FIFO with registered count
// Caller only asserts push when there is room (or a same-cycle pop) and pop when non-empty.
module fifo_sync #(
  parameter int WIDTH      = 36,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately unreset; the count alone decides what is valid.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign full      = (count_q == FULL_COUNT);
  assign empty     = (count_q == '0);
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/io_port_responder.sv
// rtl/io_port_responder.sv - datapath I/O port with outbound/inbound FIFOs and sticky errors
module io_port_responder
  import io_port_responder_pkg::*;
#(
  parameter int WORD_WIDTH = IO_WORD_WIDTH,
  parameter int DEPTH      = IO_FIFO_DEPTH,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  io_wren,
  input  logic [WORD_WIDTH-1:0] io_out,
  input  logic                  io_rden,
  output logic [WORD_WIDTH-1:0] io_in,
  output logic                  io_out_ready,
  output logic                  io_in_valid,
  output logic [WORD_WIDTH-1:0] ext_out_data,
  output logic                  ext_out_valid,
  input  logic                  ext_out_ready,
  input  logic [WORD_WIDTH-1:0] ext_in_data,
  input  logic                  ext_in_valid,
  output logic                  ext_in_ready,
  input  logic                  err_clear,
  output logic                  io_write_overflow,
  output logic                  io_read_underflow
);

  logic out_full, out_empty, out_push, out_pop;
  logic in_full, in_empty, in_push, in_pop;
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // A full outbound FIFO still takes a write when the sink drains in the same cycle.
  assign out_pop  = !out_empty && ext_out_ready;
  assign out_push = io_wren && (!out_full || out_pop);
  // Inbound readiness is purely registered, so no same-cycle pop credit here.
  assign in_push  = ext_in_valid && !in_full;
  assign in_pop   = io_rden && !in_empty;

  fifo_sync #(.WIDTH(WORD_WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_out_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (out_push),
    .push_data (io_out),
    .pop       (out_pop),
    .head_data (ext_out_data),
    .full      (out_full),
    .empty     (out_empty)
  );

  fifo_sync #(.WIDTH(WORD_WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_in_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (in_push),
    .push_data (ext_in_data),
    .pop       (in_pop),
    .head_data (io_in),
    .full      (in_full),
    .empty     (in_empty)
  );

  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (err_clear) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (io_wren && !out_push) overflow_d  = 1'b1;
    if (io_rden && in_empty)  underflow_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign io_out_ready      = !out_full;
  assign io_in_valid       = !in_empty;
  assign ext_out_valid     = !out_empty;
  assign ext_in_ready      = !in_full;
  assign io_write_overflow = overflow_q;
  assign io_read_underflow = underflow_q;

endmodule

// File: tb/tb_io_port_responder.sv
// tb/tb_io_port_responder.sv - scoreboard bench for io_port_responder
module tb_io_port_responder;
  localparam int W = 36;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         io_wren, io_rden, ext_out_ready, ext_in_valid, err_clear;
  logic [W-1:0] io_out, ext_in_data;
  logic [W-1:0] io_in, ext_out_data;
  logic         io_out_ready, io_in_valid, ext_out_valid, ext_in_ready;
  logic         io_write_overflow, io_read_underflow;

  int cmp_count  = 0;
  int fail_count = 0;
  logic [W-1:0] exp_out_q[$];
  logic [W-1:0] exp_in_q[$];
  logic [W-1:0] e;

  io_port_responder dut (
    .clock(clock), .reset_n(reset_n),
    .io_wren(io_wren), .io_out(io_out), .io_rden(io_rden), .io_in(io_in),
    .io_out_ready(io_out_ready), .io_in_valid(io_in_valid),
    .ext_out_data(ext_out_data), .ext_out_valid(ext_out_valid), .ext_out_ready(ext_out_ready),
    .ext_in_data(ext_in_data), .ext_in_valid(ext_in_valid), .ext_in_ready(ext_in_ready),
    .err_clear(err_clear),
    .io_write_overflow(io_write_overflow), .io_read_underflow(io_read_underflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_count++;
    if (act !== exp) begin
      fail_count++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: samples handshakes mid-cycle, just before the edge that completes them.
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      if (ext_out_valid && ext_out_ready) begin
        if (exp_out_q.size() == 0) check("ext_out_unexpected", 64'(ext_out_data), 64'hDEAD);
        else begin
          e = exp_out_q.pop_front();
          check("ext_out_data", 64'(ext_out_data), 64'(e));
        end
      end
      if (io_rden && io_in_valid) begin
        if (exp_in_q.size() == 0) check("io_in_unexpected", 64'(io_in), 64'hDEAD);
        else begin
          e = exp_in_q.pop_front();
          check("io_in", 64'(io_in), 64'(e));
        end
      end
    end
  end

  task automatic idle_inputs();
    io_wren = 0; io_rden = 0; ext_out_ready = 0; ext_in_valid = 0; err_clear = 0;
    io_out = '0; ext_in_data = '0;
  endtask

  task automatic wr_out(input logic [W-1:0] d, input bit expect_accept);
    io_wren = 1; io_out = d;
    if (expect_accept) exp_out_q.push_back(d);
    tick();
    io_wren = 0;
  endtask

  task automatic check_idle_state(input string tag);
    check({tag, "_io_out_ready"}, 64'(io_out_ready), 64'd1);
    check({tag, "_ext_in_ready"}, 64'(ext_in_ready), 64'd1);
    check({tag, "_io_in_valid"}, 64'(io_in_valid), 64'd0);
    check({tag, "_ext_out_valid"}, 64'(ext_out_valid), 64'd0);
    check({tag, "_io_in"}, 64'(io_in), 64'd0);
  endtask

  initial begin
    idle_inputs();
    reset_n = 0;
    #2;
    check_idle_state("reset");
    check("reset_ovf", 64'(io_write_overflow), 64'd0);
    check("reset_udf", 64'(io_read_underflow), 64'd0);
    #20 reset_n = 1;
    tick();

    // Fill outbound, overflow on fifth, then drain in order.
    for (int i = 1; i <= 4; i++) wr_out(W'(i), 1'b1);
    check("full_io_out_ready", 64'(io_out_ready), 64'd0);
    check("full_ext_out_valid", 64'(ext_out_valid), 64'd1);
    check("full_no_ovf", 64'(io_write_overflow), 64'd0);
    wr_out(W'(5), 1'b0);
    check("ovf_set", 64'(io_write_overflow), 64'd1);
    ext_out_ready = 1;
    repeat (4) tick();
    ext_out_ready = 0;
    check("drained_valid", 64'(ext_out_valid), 64'd0);
    err_clear = 1; tick(); err_clear = 0;
    check("ovf_cleared", 64'(io_write_overflow), 64'd0);

    // Full plus simultaneous write and pop.
    for (int i = 0; i < 4; i++) wr_out(W'(36'h11 + i), 1'b1);
    ext_out_ready = 1;
    wr_out(W'(36'hA), 1'b1);
    ext_out_ready = 0;
    check("simul_no_ovf", 64'(io_write_overflow), 64'd0);
    check("simul_still_full", 64'(io_out_ready), 64'd0);
    ext_out_ready = 1;
    repeat (4) tick();
    ext_out_ready = 0;
    check("simul_drained", 64'(ext_out_valid), 64'd0);

    // Underflow, clear, and set-beats-clear.
    io_rden = 1;
    #1 check("udf_io_in_zero", 64'(io_in), 64'd0);
    tick(); io_rden = 0;
    check("udf_set", 64'(io_read_underflow), 64'd1);
    check("udf_no_valid", 64'(io_in_valid), 64'd0);
    err_clear = 1; tick(); err_clear = 0;
    check("udf_cleared", 64'(io_read_underflow), 64'd0);
    err_clear = 1; io_rden = 1; tick(); err_clear = 0; io_rden = 0;
    check("udf_set_wins", 64'(io_read_underflow), 64'd1);
    err_clear = 1; tick(); err_clear = 0;

    // Inbound one-cycle latency and pop.
    ext_in_valid = 1; ext_in_data = 36'h123; exp_in_q.push_back(36'h123);
    tick(); ext_in_valid = 0;
    check("in_valid_after_push", 64'(io_in_valid), 64'd1);
    check("in_head", 64'(io_in), 64'h123);
    io_rden = 1; tick(); io_rden = 0;
    check("in_valid_after_pop", 64'(io_in_valid), 64'd0);
    check("in_zero_after_pop", 64'(io_in), 64'd0);

    // Interleaved traffic across pointer wrap on both FIFOs.
    ext_out_ready = 1;
    for (int k = 0; k < 10; k++) begin
      io_wren = 1; io_out = W'(36'h100 + k); exp_out_q.push_back(W'(36'h100 + k));
      ext_in_valid = 1; ext_in_data = W'(36'h200 + k); exp_in_q.push_back(W'(36'h200 + k));
      io_rden = (k > 0);
      tick();
    end
    io_wren = 0; ext_in_valid = 0; io_rden = 1;
    tick();
    io_rden = 0; ext_out_ready = 0;
    check("wrap_no_ovf", 64'(io_write_overflow), 64'd0);
    check("wrap_no_udf", 64'(io_read_underflow), 64'd0);
    check("wrap_out_empty", 64'(ext_out_valid), 64'd0);
    check("wrap_in_empty", 64'(io_in_valid), 64'd0);

    // Asynchronous reset with three words buffered each side.
    for (int i = 0; i < 3; i++) begin
      io_wren = 1; io_out = W'(36'h300 + i);
      ext_in_valid = 1; ext_in_data = W'(36'h400 + i);
      tick();
    end
    idle_inputs();
    check("pre_rst_out_valid", 64'(ext_out_valid), 64'd1);
    check("pre_rst_in_valid", 64'(io_in_valid), 64'd1);
    #2 reset_n = 0;
    #1 check_idle_state("async_rst");
    #1 reset_n = 1;
    tick();
    wr_out(W'(36'h77), 1'b1);
    check("post_rst_push", 64'(ext_out_valid), 64'd1);
    ext_out_ready = 1; tick(); ext_out_ready = 0;

    check("out_queue_empty", 64'(exp_out_q.size()), 64'd0);
    check("in_queue_empty", 64'(exp_in_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
